// File: rtl/rect_fill_pkg.sv
// rtl/rect_fill_pkg.sv - shared types, screen constants and clip helper for rect_fill
package rect_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    // Clip arithmetic is one bit wider than a coordinate so X_MAX+1 never wraps.
    localparam int CLIP_W = 9;

    // Visible run length starting at 'start' of requested length 'len' on an axis ending at 'last'.
    function automatic logic [CLIP_W-1:0] clip_len(input logic [CLIP_W-1:0] start,
                                                   input logic [CLIP_W-1:0] len,
                                                   input logic [CLIP_W-1:0] last);
        logic [CLIP_W-1:0] avail;
        avail = last + CLIP_W'(1) - start;
        if (start > last) begin
            clip_len = '0;
        end else begin
            clip_len = (len < avail) ? len : avail;
        end
    endfunction

endpackage

// File: rtl/rect_clip.sv
// rtl/rect_clip.sv - combinational clipping of a rectangle request to the visible screen
module rect_clip
    import rect_fill_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic [X_W-1:0]    x0_i,
    input  logic [Y_W-1:0]    y0_i,
    input  logic [X_W-1:0]    w_i,
    input  logic [Y_W-1:0]    h_i,
    output logic [CLIP_W-1:0] ew_o,
    output logic [CLIP_W-1:0] eh_o,
    output logic              empty_o
);

    localparam logic [CLIP_W-1:0] X_LAST = CLIP_W'(X_MAX);
    localparam logic [CLIP_W-1:0] Y_LAST = CLIP_W'(Y_MAX);

    assign ew_o    = clip_len(CLIP_W'(x0_i), CLIP_W'(w_i), X_LAST);
    assign eh_o    = clip_len(CLIP_W'(y0_i), CLIP_W'(h_i), Y_LAST);
    assign empty_o = (ew_o == '0) || (eh_o == '0);

endmodule

// File: rtl/rect_fill.sv
// rtl/rect_fill.sv - clipped rectangle fill / screen clear engine driving the VGA pixel port
module rect_fill
    import rect_fill_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [X_W-1:0] req_x0,
    input  logic [Y_W-1:0] req_y0,
    input  logic [X_W-1:0] req_w,
    input  logic [Y_W-1:0] req_h,
    input  logic [C_W-1:0] req_colour,
    input  logic           req_clear,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [C_W-1:0] colour,
    output logic           plot,
    output logic           vga_resetn,
    output logic           busy,
    output logic           done
);

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [C_W-1:0]    colour_q, colour_d;
    logic              plot_q, plot_d;
    logic              vga_resetn_q, vga_resetn_d;
    logic [X_W-1:0]    x0_q, x0_d;
    logic [CLIP_W-1:0] ew_q, ew_d;
    logic [CLIP_W-1:0] eh_q, eh_d;
    logic [CLIP_W-1:0] col_q, col_d;
    logic [CLIP_W-1:0] row_q, row_d;

    logic [CLIP_W-1:0] clip_ew;
    logic [CLIP_W-1:0] clip_eh;
    logic              clip_empty;
    logic              accept;
    logic              last_col;
    logic              last_row;

    rect_clip #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_clip (
        .x0_i    (req_x0),
        .y0_i    (req_y0),
        .w_i     (req_w),
        .h_i     (req_h),
        .ew_o    (clip_ew),
        .eh_o    (clip_eh),
        .empty_o (clip_empty)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign accept     = req_valid && req_ready;
    assign last_col   = (col_q == ew_q - CLIP_W'(1));
    assign last_row   = (row_q == eh_q - CLIP_W'(1));

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign vga_resetn = vga_resetn_q;

    // Next state and next pixel; the first pixel is loaded on the accept edge so it appears one cycle later.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        vga_resetn_d = 1'b1;
        x0_d         = x0_q;
        ew_d         = ew_q;
        eh_d         = eh_q;
        col_d        = col_q;
        row_d        = row_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_clear) begin
                        state_d      = ST_CLEAR;
                        vga_resetn_d = 1'b0;
                    end else if (clip_empty) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_DRAW;
                        x_d      = req_x0;
                        y_d      = req_y0;
                        colour_d = req_colour;
                        plot_d   = 1'b1;
                        x0_d     = req_x0;
                        ew_d     = clip_ew;
                        eh_d     = clip_eh;
                        col_d    = '0;
                        row_d    = '0;
                    end
                end
            end
            ST_DRAW: begin
                if (last_col) begin
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        col_d  = '0;
                        row_d  = row_q + CLIP_W'(1);
                        x_d    = x0_q;
                        y_d    = y_q + Y_W'(1);
                        plot_d = 1'b1;
                    end
                end else begin
                    col_d  = col_q + CLIP_W'(1);
                    x_d    = x_q + X_W'(1);
                    plot_d = 1'b1;
                end
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any command in flight without waiting for a clock.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            vga_resetn_q <= 1'b1;
            x0_q         <= '0;
            ew_q         <= '0;
            eh_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            vga_resetn_q <= vga_resetn_d;
            x0_q         <= x0_d;
            ew_q         <= ew_d;
            eh_q         <= eh_d;
            col_q        <= col_d;
            row_q        <= row_d;
        end
    end

endmodule

// File: tb/tb_rect_fill.sv
// tb/tb_rect_fill.sv - self-checking bench for rect_fill
module tb_rect_fill;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x0;
    logic [6:0] req_y0;
    logic [7:0] req_w;
    logic [6:0] req_h;
    logic [2:0] req_colour;
    logic       req_clear;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       vga_resetn;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    rect_fill dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x0     (req_x0),
        .req_y0     (req_y0),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .req_clear  (req_clear),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .vga_resetn (vga_resetn),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] x0;
        logic [6:0] y0;
        logic [7:0] w;
        logic [6:0] h;
        logic [2:0] c;
        logic       clr;
        int         ew;
        int         eh;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] w,
                         input logic [6:0] h, input logic [2:0] c, input logic clr);
        req_x0     = x0;
        req_y0     = y0;
        req_w      = w;
        req_h      = h;
        req_colour = c;
        req_clear  = clr;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int g;
        int n;
        int done_t;
        int idx;
        logic exp_plot;
        g = 0;
        while (!req_ready && g < 50) begin
            step();
            g++;
        end
        chk($sformatf("v%0d ready_before", id), req_ready, 1);
        drive(v.x0, v.y0, v.w, v.h, v.c, v.clr);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_clear = 1'b0;
        n      = v.ew * v.eh;
        done_t = v.clr ? 2 : n + 1;
        idx    = 0;
        for (int t = 1; t <= done_t + 1; t++) begin
            exp_plot = !v.clr && (t <= n);
            chk($sformatf("v%0d t%0d plot", id, t), plot, exp_plot);
            if (exp_plot) begin
                chk($sformatf("v%0d t%0d x", id, t), x, v.x0 + (idx % v.ew));
                chk($sformatf("v%0d t%0d y", id, t), y, v.y0 + (idx / v.ew));
                chk($sformatf("v%0d t%0d colour", id, t), colour, v.c);
                idx++;
            end
            chk($sformatf("v%0d t%0d vga_resetn", id, t), vga_resetn, !(v.clr && t == 1));
            chk($sformatf("v%0d t%0d done", id, t), done, t == done_t);
            chk($sformatf("v%0d t%0d ready", id, t), req_ready, t == done_t + 1);
            chk($sformatf("v%0d t%0d busy", id, t), busy, t != done_t + 1);
            if (t <= done_t) step();
        end
    endtask

    initial begin
        logic       b_plot[8];
        int         b_x[8];
        int         b_y[8];
        int         b_c[8];
        logic       b_done[8];
        logic       b_ready[8];
        int         g;

        //           x0     y0     w       h      c     clr   ew  eh
        vecs[0] = '{8'd10, 7'd20, 8'd3,   7'd2,  3'd5, 1'b0, 3,  2};
        vecs[1] = '{8'd158,7'd119,8'd4,   7'd3,  3'd2, 1'b0, 2,  1};
        vecs[2] = '{8'd5,  7'd5,  8'd0,   7'd4,  3'd1, 1'b0, 0,  4};
        vecs[3] = '{8'd200,7'd5,  8'd3,   7'd3,  3'd4, 1'b0, 0,  3};
        vecs[4] = '{8'd7,  7'd9,  8'd5,   7'd5,  3'd6, 1'b1, 0,  0};
        vecs[5] = '{8'd3,  7'd125,8'd2,   7'd2,  3'd3, 1'b0, 2,  0};
        vecs[6] = '{8'd0,  7'd0,  8'd160, 7'd1,  3'd7, 1'b0, 160,1};
        vecs[7] = '{8'd159,7'd0,  8'd1,   7'd1,  3'd1, 1'b0, 1,  1};
        vecs[8] = '{8'd100,7'd110,8'd255, 7'd127,3'd4, 1'b0, 60, 10};

        reset     = 1'b1;
        req_valid = 1'b0;
        drive(8'd0, 7'd0, 8'd0, 7'd0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst x", x, 0);
        chk("rst y", y, 0);
        chk("rst colour", colour, 0);
        chk("rst plot", plot, 0);
        chk("rst vga_resetn", vga_resetn, 1);
        chk("rst done", done, 0);
        chk("rst busy", busy, 0);
        chk("rst ready", req_ready, 1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
            step();
        end

        // Back-to-back with req_valid held: second command waits for ready to return.
        b_plot  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        b_x     = '{2, 3, 0, 0, 50, 51, 0, 0};
        b_y     = '{2, 2, 0, 0, 60, 60, 0, 0};
        b_c     = '{1, 1, 0, 0, 3, 3, 0, 0};
        b_done  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        b_ready = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        chk("b2b ready_before", req_ready, 1);
        drive(8'd2, 7'd2, 8'd2, 7'd1, 3'd1, 1'b0);
        req_valid = 1'b1;
        step();
        drive(8'd50, 7'd60, 8'd2, 7'd1, 3'd3, 1'b0);
        for (int t = 1; t <= 8; t++) begin
            if (t == 5) req_valid = 1'b0;
            chk($sformatf("b2b t%0d plot", t), plot, b_plot[t-1]);
            if (b_plot[t-1]) begin
                chk($sformatf("b2b t%0d x", t), x, b_x[t-1]);
                chk($sformatf("b2b t%0d y", t), y, b_y[t-1]);
                chk($sformatf("b2b t%0d colour", t), colour, b_c[t-1]);
            end
            chk($sformatf("b2b t%0d done", t), done, b_done[t-1]);
            chk($sformatf("b2b t%0d ready", t), req_ready, b_ready[t-1]);
            if (t < 8) step();
        end
        step();

        // Reset pulsed mid-draw after the third plot of a 4x4 rectangle.
        drive(8'd30, 7'd40, 8'd4, 7'd4, 3'd6, 1'b0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            chk($sformatf("mid t%0d plot", t), plot, 1);
            chk($sformatf("mid t%0d x", t), x, 30 + t - 1);
            if (t < 3) step();
        end
        #3;
        reset = 1'b1;
        #1;
        chk("mid async plot", plot, 0);
        chk("mid async x", x, 0);
        chk("mid async y", y, 0);
        chk("mid async colour", colour, 0);
        chk("mid async vga_resetn", vga_resetn, 1);
        chk("mid async busy", busy, 0);
        chk("mid async ready", req_ready, 1);
        chk("mid async done", done, 0);
        step();
        reset = 1'b0;
        for (int t = 0; t < 6; t++) begin
            chk($sformatf("post t%0d plot", t), plot, 0);
            chk($sformatf("post t%0d done", t), done, 0);
            chk($sformatf("post t%0d ready", t), req_ready, 1);
            step();
        end

        // A command after the abort still runs normally.
        g = 0;
        run_vec(99, vecs[7]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
